// File: rtl/alu_mdu_control.sv
// ---------------------------------------------------------------------------
// alu_mdu_control
//
// Execute-stage ALU control with an attached sequential multiply/divide unit.
// The decode half turns aluOp/funct3/funct7 into a 4-bit ALU operation code.
// This is purely combinational.
// The MDU half runs RV32M-style ops one radix-2 step per cycle:
//   - multiply uses shift-add;
//   - divide uses restoring division;
//   - both work on operand magnitudes, and the sign is fixed up on entry
//     to DONE.
// While the MDU is busy it holds the pipeline through stall.
//
// Configuration macro: MDU_DIV_EN
//   defined   -> all eight M-extension ops are supported.
//   undefined -> div/divu/rem/remu decode as illegal and no divider is built.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   aluOp      in   2   00 ld/st, 01 branch, 10 R-type, 11 I-type ALU
//   funct3     in   3   instruction funct3
//   funct7     in   7   instruction funct7
//   valid      in   1   instruction in execute is real
//   flush      in   1   abort any MDU operation
//   srcA/srcB  in   XLEN MDU operands (rs1, rs2)
//   operation  out  4   ALU op code (combinational)
//   illegal    out  1   unsupported encoding (combinational)
//   stall      out  1   hold pipeline while MDU busy
//   mduDone    out  1   one-cycle pulse, mduResult valid
//   mduResult  out  XLEN registered MDU result
// ---------------------------------------------------------------------------
module alu_mdu_control #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      aluOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            valid,
  input  logic            flush,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic [3:0]      operation,
  output logic            illegal,
  output logic            stall,
  output logic            mduDone,
  output logic [XLEN-1:0] mduResult
);

  localparam int CNT_W = $clog2(XLEN + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_MDU  = 4'b1110;
  localparam logic [3:0] OP_ILL  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // funct3 map shared by R-type (funct7 = 0) and I-type ALU ops
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  // Sign fixup of the raw magnitude result held in the shared register.
  // For multiply, raw is the full 2*XLEN product.
  // For divide, raw holds {remainder, quotient}.
  function automatic logic [XLEN-1:0] fix_result(input logic [2*XLEN-1:0] raw,
                                                 input logic [2:0]        f3,
                                                 input logic              neg);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res;
    prod = neg ? -raw : raw;
    res  = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
    if (f3[2]) begin
      if (f3[1]) res = neg ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
      else       res = neg ? -raw[XLEN-1:0]      : raw[XLEN-1:0];
    end
`endif
    return res;
  endfunction

  // ---------------- decode ----------------
  always_comb begin
    operation = OP_ILL;
    case (aluOp)
      2'b00: operation = OP_ADD;
      2'b01: operation = OP_SUB;
      2'b10: begin
        if (funct7 == 7'b0000000) begin
          operation = base_op(funct3);
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      operation = OP_SUB;
          else if (funct3 == 3'b101) operation = OP_SRA;
        end else if (funct7 == 7'b0000001) begin
`ifdef MDU_DIV_EN
          operation = OP_MDU;
`else
          if (!funct3[2]) operation = OP_MDU;
`endif
        end
      end
      default: begin
        // I-type: shifts still look at the funct7 field of the immediate
        if (funct3 == 3'b001) begin
          if (funct7 == 7'b0000000) operation = OP_SLL;
        end else if (funct3 == 3'b101) begin
          operation = funct7[5] ? OP_SRA : OP_SRL;
        end else begin
          operation = base_op(funct3);
        end
      end
    endcase
  end

  assign illegal = (operation == OP_ILL);

  // ---------------- MDU ----------------
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       opnd_q, opnd_d;
  logic [2:0]            f3_q, f3_d;
  logic                  neg_q, neg_d;

  logic                  is_mdu, start;
  logic                  a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]       abs_a, abs_b;
  logic                  is_div_req, div_zero, div_ovf, is_div_q;
  logic [XLEN-1:0]       special_res;
  logic [XLEN:0]         mul_sum;
  logic [2*XLEN:0]       mul_cat;
  logic [2*XLEN-1:0]     step_val;

  assign is_mdu = (operation == OP_MDU);
  assign start  = valid & is_mdu & ~illegal & ~flush;

  always_comb begin
    // mul/mulh/mulhsu and div/rem treat rs1 as signed; only mul/mulh/div/rem sign rs2
    a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    sign_a   = a_signed & srcA[XLEN-1];
    sign_b   = b_signed & srcB[XLEN-1];
    abs_a    = sign_a ? -srcA : srcA;
    abs_b    = sign_b ? -srcB : srcB;
  end

`ifdef MDU_DIV_EN
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic [XLEN:0] div_shift, div_diff;

  always_comb begin
    is_div_req  = funct3[2];
    div_zero    = is_div_req & (srcB == '0);
    div_ovf     = is_div_req & ~funct3[0] & (srcA == INT_MIN) & (srcB == '1);
    special_res = '0;
    if (div_zero)     special_res = funct3[1] ? srcA : '1;
    else if (div_ovf) special_res = funct3[1] ? '0 : srcA;
  end

  assign is_div_q = f3_q[2];
`else
  always_comb begin
    is_div_req  = 1'b0;
    div_zero    = 1'b0;
    div_ovf     = 1'b0;
    special_res = '0;
  end

  assign is_div_q = 1'b0;
`endif

  // One radix-2 step; acc_q holds {partial product, multiplier} for multiply
  // and {partial remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    mul_cat  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:0]} : {1'b0, acc_q};
    step_val = mul_cat[2*XLEN:1];
`ifdef MDU_DIV_EN
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      step_val = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d   = funct3;
          // remainder follows the dividend sign; everything else is the sign product
          neg_d  = (funct3[2] & funct3[1]) ? sign_a : (sign_a ^ sign_b);
          cnt_d  = CNT_W'(XLEN);
          acc_d  = {{XLEN{1'b0}}, (is_div_req ? abs_a : abs_b)};
          opnd_d = is_div_req ? abs_b : abs_a;
          if (div_zero | div_ovf) begin
            state_d  = S_DONE;
            result_d = special_res;
          end else begin
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_val;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d  = S_DONE;
            result_d = fix_result(step_val, f3_q, neg_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
    f3_q   <= f3_d;
    neg_q  <= neg_d;
  end

  assign stall     = (valid & is_mdu & (state_q == S_IDLE) & ~flush) | (state_q == S_RUN);
  assign mduDone   = (state_q == S_DONE) & ~flush;
  assign mduResult = result_q;

endmodule
